// File: rtl/add64_arb_pkg.sv
// Shared types and helpers for the 64-bit adder slot arbiter.
package add64_arb_pkg;
  localparam int ADD_W   = 64;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  // Pointer moves to the slot after the granted one; holds when nothing was granted.
  function automatic int unsigned next_rr(input int unsigned ptr, input logic [MAX_REQ-1:0] grant,
                                          input int unsigned n);
    int unsigned nxt;
    nxt = ptr;
    for (int i = 0; i < MAX_REQ; i++)
      if (grant[i]) nxt = (32'(i + 1) == n) ? 32'd0 : 32'(i + 1);
    return nxt;
  endfunction
endpackage

// File: rtl/add64_tag_pipe.sv
// Valid+id shift register that follows each issued add through the adder pipeline.
module add64_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id
);
  logic [DEPTH-1:0]           vld_pipe;
  logic [DEPTH-1:0][ID_W-1:0] id_pipe;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      id_pipe[0]  <= in_id;
      for (int k = 1; k < DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
    end
  end

  assign out_valid = vld_pipe[DEPTH-1];
  assign out_id    = id_pipe[DEPTH-1];
endmodule

// File: rtl/add64_slot_arbiter.sv
// Round-robin sharing of one pipelined 64-bit adder between issue slots, with flush/drain.
// Optional ADD64_ARB_PERF_EN adds per-slot grant counters and an idle-cycle counter.
module add64_slot_arbiter
  import add64_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*ADD_W-1:0] req_a,
  input  logic [NUM_REQ*ADD_W-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     add_valid,
  output logic [ADD_W-1:0]         add_a,
  output logic [ADD_W-1:0]         add_b,
  input  logic [ADD_W-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [ADD_W-1:0]         rsp_sum,
  output logic                     rsp_cout,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     busy
`ifdef ADD64_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]    perf_grants,
  output logic [31:0]              perf_idle
`endif
);
  localparam int CNT_W = $clog2(ADD_LAT + 3);

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr;
  logic [CNT_W-1:0]     inflight;
  logic                 pulsed;
  logic                 allow, found, drained;
  logic [NUM_REQ-1:0]   arb, grant;
  logic [ID_W-1:0]      gid;
  logic [ADD_W-1:0]     sel_a, sel_b;
  logic                 tag_vld;
  logic [ID_W-1:0]      tag_id;
  int                   idx;

  always_comb begin
    arb   = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = (int'(rr) + o) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        arb[idx] = 1'b1;
        gid      = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        sel_a = req_a[i*ADD_W +: ADD_W];
        sel_b = req_b[i*ADD_W +: ADD_W];
      end
  end

  // Last response leaving this cycle counts as drained, so flush_done lands right after it.
  assign drained = (inflight == '0) || (inflight == CNT_W'(1) && rsp_valid);

  always_comb begin
    state_nxt  = state;
    allow      = 1'b0;
    flush_done = 1'b0;
    case (state)
      RUN:   if (flush_req) state_nxt = DRAIN; else allow = 1'b1;
      DRAIN: if (drained) begin
               if (!pulsed)        state_nxt = DONE;
               else if (!flush_req) state_nxt = RUN;
             end
      DONE:  begin
               flush_done = 1'b1;
               state_nxt  = flush_req ? DRAIN : RUN;
             end
      default: state_nxt = RUN;
    endcase
  end

  assign grant     = (allow && reset) ? arb : '0;
  assign req_ready = grant;
  assign busy      = (inflight != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      rr        <= '0;
      pulsed    <= 1'b0;
      inflight  <= '0;
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      state     <= state_nxt;
      add_valid <= |grant;
      if (|grant) begin
        rr    <= ID_W'(next_rr(32'(rr), MAX_REQ'(grant), NUM_REQ));
        add_a <= sel_a;
        add_b <= sel_b;
      end
      if (state == DONE)   pulsed <= 1'b1;
      else if (!flush_req) pulsed <= 1'b0;
      case ({|grant, rsp_valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      rsp_valid <= tag_vld;
      if (tag_vld) begin
        rsp_id   <= tag_id;
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
      end
    end
  end

  add64_tag_pipe #(.DEPTH(ADD_LAT + 1), .ID_W(ID_W)) u_tag (
    .clk      (clk),
    .reset    (reset),
    .in_valid (|grant),
    .in_id    (gid),
    .out_valid(tag_vld),
    .out_id   (tag_id)
  );

`ifdef ADD64_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] gcnt;
  logic [31:0]              icnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      gcnt <= '0;
      icnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant[i] && gcnt[i] != '1) gcnt[i] <= gcnt[i] + 32'd1;
      if (state == RUN && grant == '0 && icnt != '1) icnt <= icnt + 32'd1;
    end
  end

  assign perf_grants = gcnt;
  assign perf_idle   = icnt;
`endif
endmodule

// File: tb/tb_add64_slot_arbiter.sv
// Directed bench for add64_slot_arbiter: behavioural adder, cycle-level model, literal pins.
module tb_add64_slot_arbiter;
  localparam int N  = 4;
  localparam int L  = 2;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [63:0]     a_in [N];
  logic [63:0]     b_in [N];
  logic [N*64-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            add_valid, add_cout, rsp_valid, rsp_cout, flush_done, busy;
  logic            flush_req = 1'b0;
  logic [63:0]     add_a, add_b, add_sum, rsp_sum;
  logic [IW-1:0]   rsp_id;
`ifdef ADD64_ARB_PERF_EN
  logic [N*32-1:0] perf_grants;
  logic [31:0]     perf_idle;
`endif

  always_comb
    for (int i = 0; i < N; i++) begin
      req_a[i*64 +: 64] = a_in[i];
      req_b[i*64 +: 64] = b_in[i];
    end

  add64_slot_arbiter #(.NUM_REQ(N), .ADD_LAT(L), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_cout(add_cout), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .flush_req(flush_req), .flush_done(flush_done),
    .busy(busy)
`ifdef ADD64_ARB_PERF_EN
    , .perf_grants(perf_grants), .perf_idle(perf_idle)
`endif
  );

  // Adder stand-in: L-cycle pipelined 65-bit sum of the registered operands.
  logic [64:0] apipe [L];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b};
    for (int k = 1; k < L; k++) apipe[k] <= apipe[k-1];
  end
  assign add_sum  = apipe[L-1][63:0];
  assign add_cout = apipe[L-1][64];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: every grant becomes a record due back exactly L+2 cycles later.
  typedef struct { int gc; int rc; logic [IW-1:0] id; logic [64:0] s; } ent_t;
  ent_t        q[$];
  int          m_rr = 0, m_ph = 0, m_done = 0;  // phase 0 run, 1 draining, 2 waiting for flush drop
  logic        pv = 1'b0;
  logic [63:0] pa = '0, pb = '0;
  bit          started = 0;

  always @(negedge clk) if (started) begin
    logic [N-1:0] er;
    int           k, lastr;
    logic         erv, eb;
    ent_t         ee;
    er = '0; k = -1;
    if (reset && m_ph == 0 && !flush_req)
      for (int o = 0; o < N; o++) begin
        int i;
        i = (m_rr + o) % N;
        if (k < 0 && req_valid[i]) k = i;
      end
    if (k >= 0) er[k] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("add_valid", add_valid, pv);
    if (pv) begin
      chk("add_a", add_a, pa);
      chk("add_b", add_b, pb);
    end
    erv = 1'b0; eb = 1'b0; lastr = 0; ee = '{default: 0};
    foreach (q[j]) begin
      if (q[j].rc == cyc) begin erv = 1'b1; ee = q[j]; end
      if (q[j].gc < cyc && cyc <= q[j].rc) eb = 1'b1;
      if (q[j].rc > lastr) lastr = q[j].rc;
    end
    chk("rsp_valid", rsp_valid, erv);
    if (erv) begin
      chk("rsp_id", rsp_id, ee.id);
      chk("rsp_sum", rsp_sum, ee.s[63:0]);
      chk("rsp_cout", rsp_cout, ee.s[64]);
    end
    chk("busy", busy, eb);
    chk("flush_done", flush_done, (m_ph == 1 && cyc == m_done));
    if (!reset) begin
      q.delete();
      m_rr = 0; m_ph = 0; pv = 1'b0; pa = '0; pb = '0;
    end else begin
      pv = (k >= 0);
      if (k >= 0) begin
        ee.gc = cyc; ee.rc = cyc + L + 2; ee.id = IW'(k);
        ee.s  = {1'b0, a_in[k]} + {1'b0, b_in[k]};
        q.push_back(ee);
        pa = a_in[k]; pb = b_in[k];
        m_rr = (k + 1) % N;
      end
      while (q.size() > 0 && q[0].rc <= cyc) void'(q.pop_front());
      case (m_ph)
        0: if (flush_req) begin
             m_ph = 1;
             m_done = (lastr + 1 > cyc + 2) ? lastr + 1 : cyc + 2;
           end
        1: if (cyc == m_done) m_ph = flush_req ? 2 : 0;
        default: if (!flush_req) m_ph = 0;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rst();
    reset = 1'b0; req_valid = '0; flush_req = 1'b0;
    step(1);
    reset = 1'b1;
  endtask

  logic [3:0] got2 [5];
  logic [3:0] exp2 [5];
  int nz, nrsp, ndone, dk, lastk, stale;

  initial begin
    for (int i = 0; i < N; i++) begin a_in[i] = '0; b_in[i] = '0; end
    step(2);
    reset = 1'b1;
    started = 1;
    @(negedge clk);
    chk("rst_add_valid", add_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_add_a", add_a, 64'd0);
    chk("rst_rsp_sum", rsp_sum, 64'd0);
    step(1);

    // 1: lone request from slot 2
    a_in[2] = 64'd5; b_in[2] = 64'd7; req_valid = 4'b0100;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0100);
    step(1);
    req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_id", rsp_id, 2'd2);
    chk("t1_rsp_sum", rsp_sum, 64'd12);
    chk("t1_rsp_cout", rsp_cout, 1'b0);
    step(2);

    // 2: all slots requesting continuously
    rst();
    for (int i = 0; i < N; i++) begin a_in[i] = 64'h100 * (i + 1); b_in[i] = 64'(i); end
    exp2[0] = 4'b0001; exp2[1] = 4'b0010; exp2[2] = 4'b0100; exp2[3] = 4'b1000; exp2[4] = 4'b0001;
    req_valid = 4'hF;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      got2[j] = req_ready;
      step(1);
    end
    req_valid = '0;
    for (int j = 0; j < 5; j++) chk("t2_grant_order", got2[j], exp2[j]);
    step(8);

    // 3: carry out of the top bit, slot 3
    a_in[3] = 64'hFFFF_FFFF_FFFF_FFFF; b_in[3] = 64'd1; req_valid = 4'b1000;
    step(1);
    req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t3_rsp_valid", rsp_valid, 1'b1);
    chk("t3_rsp_id", rsp_id, 2'd3);
    chk("t3_rsp_sum", rsp_sum, 64'd0);
    chk("t3_rsp_cout", rsp_cout, 1'b1);
    step(2);

    // 4: flush with three adds in flight and slot 1 waiting
    rst();
    for (int i = 0; i < N; i++) begin a_in[i] = 64'h1234 + 64'(i); b_in[i] = 64'h10 << i; end
    req_valid = 4'b1101;
    step(3);
    req_valid = 4'b0010; flush_req = 1'b1;
    nz = 0; nrsp = 0; ndone = 0; dk = -1; lastk = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready != '0) nz++;
      if (rsp_valid) begin nrsp++; lastk = k; end
      if (flush_done) begin ndone++; dk = k; end
      step(1);
    end
    chk("t4_no_grant", nz, 0);
    chk("t4_rsp_count", nrsp, 3);
    chk("t4_done_count", ndone, 1);
    chk("t4_done_at", dk, 4);
    chk("t4_done_after_last", dk, lastk + 1);
    flush_req = 1'b0;
    @(negedge clk);
    chk("t4_ready_hold", req_ready, 4'b0000);
    step(1);
    @(negedge clk);
    chk("t4_ready_resume", req_ready, 4'b0010);
    step(1);
    req_valid = '0;
    step(6);

    // 5: reset with two adds in flight
    rst();
    req_valid = 4'b0011;
    step(2);
    req_valid = '0; reset = 1'b0;
    step(1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_add_valid", add_valid, 1'b0);
    chk("t5_rsp_valid", rsp_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_add_a", add_a, 64'd0);
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("t5_stale_rsp", stale, 0);
    step(1);

`ifdef ADD64_ARB_PERF_EN
    // 6: performance counters
    rst();
    req_valid = 4'b0001;
    step(10);
    req_valid = '0;
    step(5);
    chk("t6_perf_grants0", perf_grants[31:0], 32'd10);
    chk("t6_perf_idle", perf_idle, 32'd5);
    step(6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
